cam_capture: RTL and testbench

Camera capture stage for the frame-buffer path: it samples an OV7670-style 8-bit pixel bus (vsync, href, byte data) and assembles byte pairs into 16-bit RGB565 pixels. It generates the write-port address, data and write strobe of the dual-port frame buffer, one pixel per write, in raster order. It also frames captures on vsync and reports frame completion to the control logic.

---
 rtl/cam_capture.sv | 136 +++++++++++++
 tb/tb_cam_capture.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture.sv
// cam_capture: samples an OV7670-style 8-bit pixel bus and writes RGB565
// pixels (two bytes each) into a frame buffer in raster order. Captures are
// framed on vsync; frame completion is reported with a one-cycle pulse.
//
// Write-port handshake: regwrite is a one-cycle strobe with no back-pressure;
// addr_in/data_in are valid whenever regwrite is high and hold their last
// values otherwise. The frame buffer must accept a write on every strobe.
module cam_capture #(
  parameter int AW    = 17,
  parameter int DW    = 16,
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  input  logic          capture_en,
  output logic [AW-1:0] addr_in,
  output logic [DW-1:0] data_in,
  output logic          regwrite,
  output logic          busy,
  output logic          frame_done,
  output logic [1:0]    state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // One extra counter bit so the count can sit at IMG_W*IMG_H once full.
  localparam logic [AW:0] NPIX = (AW+1)'(IMG_W * IMG_H);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  state_t          state_q, state_d;
  logic            vsync_q;
  logic            phase_q;
  logic [7:0]      hi_q;
  logic [AW:0]     cnt_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q;
  logic            regwrite_q;
  logic            busy_q;
  logic            frame_done_q;

  logic            frame_start;
  logic            frame_end;
  logic            take_byte;

  assign frame_start = vsync_q & ~vsync;
  assign frame_end   = ~vsync_q & vsync;
  // A byte that coincides with the frame-end edge is not part of the frame.
  assign take_byte   = (state_q == CAPTURE) && href && !frame_end;

  // Next-state logic for the capture FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (capture_en) state_d = WAIT_VS;
      end
      WAIT_VS: begin
        if (!capture_en)      state_d = IDLE;
        else if (frame_start) state_d = CAPTURE;
      end
      CAPTURE: begin
        // capture_en is deliberately ignored so a frame is never cut short.
        if (frame_end) state_d = DONE;
      end
      DONE: begin
        state_d = capture_en ? WAIT_VS : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Sync edge detection, byte pairing, pixel addressing and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_q      <= 1'b0;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      cnt_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      regwrite_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      vsync_q      <= vsync;
      regwrite_q   <= 1'b0;
      busy_q       <= (state_d == WAIT_VS) || (state_d == CAPTURE);
      // The pulse follows the DONE cycle, two clocks after vsync rises.
      frame_done_q <= (state_q == DONE);
      if ((state_q == WAIT_VS) && (state_d == CAPTURE)) begin
        cnt_q   <= '0;
        phase_q <= 1'b0;
      end else if (take_byte) begin
        if (!phase_q) begin
          hi_q    <= px_data;
          phase_q <= 1'b1;
        end else begin
          phase_q <= 1'b0;
          // Pixels beyond the buffer are dropped; the count saturates.
          if (cnt_q < NPIX) begin
            regwrite_q <= 1'b1;
            addr_q     <= cnt_q[AW-1:0];
            data_q     <= {hi_q, px_data};
            cnt_q      <= cnt_q + ONE;
          end
        end
      end else begin
        // href low (or not capturing) discards any dangling high byte.
        phase_q <= 1'b0;
      end
    end
  end

  assign addr_in    = addr_q;
  assign data_in    = data_q;
  assign regwrite   = regwrite_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture with a 4x2 frame buffer. Inputs change on the
// falling edge; outputs are observed on the falling edge after each rising edge.
module tb_cam_capture;

  localparam int AW    = 17;
  localparam int DW    = 16;
  localparam int IMG_W = 4;
  localparam int IMG_H = 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic          clk;
  logic          rst;
  logic          vsync;
  logic          href;
  logic [7:0]    px_data;
  logic          capture_en;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic          regwrite;
  logic          busy;
  logic          frame_done;
  logic [1:0]    state_o;

  int passed = 0;
  int total  = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] got_q[$];

  cam_capture #(.AW(AW), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk        (clk),
    .rst        (rst),
    .vsync      (vsync),
    .href       (href),
    .px_data    (px_data),
    .capture_en (capture_en),
    .addr_in    (addr_in),
    .data_in    (data_in),
    .regwrite   (regwrite),
    .busy       (busy),
    .frame_done (frame_done),
    .state_o    (state_o)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor feeding the scoreboard
  always @(negedge clk) begin
    if (rst && regwrite) got_q.push_back({addr_in, data_in});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one cycle of camera bus; returns at the following falling edge.
  task automatic tick(input logic v, input logic h, input logic [7:0] d);
    vsync   = v;
    href    = h;
    px_data = d;
    @(negedge clk);
  endtask

  task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
    chk("wr_strobe", 64'(regwrite), 64'd1);
    chk("wr_addr", 64'(addr_in), 64'(a));
    chk("wr_data", 64'(data_in), 64'(d));
  endtask

  initial begin
    logic [7:0] hb;
    logic [7:0] lb;
    rst = 1'b0; vsync = 1'b0; href = 1'b0; px_data = '0; capture_en = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_addr", 64'(addr_in), 64'd0);
    chk("rst_data", 64'(data_in), 64'd0);
    chk("rst_regwrite", 64'(regwrite), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_state", 64'(state_o), 64'(S_IDLE));
    rst = 1'b1;

    // Single line, 4 bytes
    capture_en = 1'b1;
    tick(1'b1, 1'b0, 8'h00);
    chk("arm_state", 64'(state_o), 64'(S_WAIT));
    chk("arm_busy", 64'(busy), 64'd1);
    tick(1'b0, 1'b0, 8'h00);
    chk("start_state", 64'(state_o), 64'(S_CAPT));
    tick(1'b0, 1'b1, 8'hA1);
    chk("l1_b1_nowr", 64'(regwrite), 64'd0);
    tick(1'b0, 1'b1, 8'hB2);
    exp_wr(17'd0, 16'hA1B2);
    tick(1'b0, 1'b1, 8'hC3);
    chk("l1_b3_nowr", 64'(regwrite), 64'd0);
    chk("l1_hold_addr", 64'(addr_in), 64'd0);
    chk("l1_hold_data", 64'(data_in), 64'hA1B2);
    tick(1'b0, 1'b1, 8'hD4);
    exp_wr(17'd1, 16'hC3D4);
    tick(1'b0, 1'b0, 8'h00);
    chk("l1_idle_nowr", 64'(regwrite), 64'd0);
    tick(1'b1, 1'b0, 8'h00);
    chk("f1_end_state", 64'(state_o), 64'(S_DONE));
    chk("f1_end_busy", 64'(busy), 64'd0);
    chk("f1_fd_early", 64'(frame_done), 64'd0);
    tick(1'b1, 1'b0, 8'h00);
    chk("f1_fd_pulse", 64'(frame_done), 64'd1);
    chk("f1_rearm_state", 64'(state_o), 64'(S_WAIT));
    chk("f1_rearm_busy", 64'(busy), 64'd1);
    tick(1'b1, 1'b0, 8'h00);
    chk("f1_fd_once", 64'(frame_done), 64'd0);

    // Odd byte, href gap, and a byte coinciding with frame end
    tick(1'b0, 1'b0, 8'h00);
    chk("f2_state", 64'(state_o), 64'(S_CAPT));
    tick(1'b0, 1'b1, 8'h11);
    tick(1'b0, 1'b1, 8'h22);
    exp_wr(17'd0, 16'h1122);
    tick(1'b0, 1'b1, 8'h33);
    chk("odd_nowr", 64'(regwrite), 64'd0);
    tick(1'b0, 1'b0, 8'h00);
    chk("gap_nowr", 64'(regwrite), 64'd0);
    tick(1'b0, 1'b1, 8'h44);
    chk("phase_reset_nowr", 64'(regwrite), 64'd0);
    tick(1'b0, 1'b1, 8'h55);
    exp_wr(17'd1, 16'h4455);
    tick(1'b0, 1'b1, 8'h77);
    tick(1'b1, 1'b1, 8'h88);
    chk("end_byte_nowr", 64'(regwrite), 64'd0);
    chk("f2_end_state", 64'(state_o), 64'(S_DONE));
    tick(1'b1, 1'b0, 8'h00);
    chk("f2_fd_pulse", 64'(frame_done), 64'd1);
    tick(1'b1, 1'b0, 8'h00);

    // Full 4x2 frame with 10 pixels sent
    tick(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      hb = 8'h30 + 8'(i);
      lb = 8'h90 + 8'(i);
      tick(1'b0, 1'b1, hb);
      tick(1'b0, 1'b1, lb);
      if (i < IMG_W * IMG_H) begin
        exp_wr(AW'(i), {hb, lb});
      end else begin
        chk("full_drop_nowr", 64'(regwrite), 64'd0);
        chk("full_drop_addr", 64'(addr_in), 64'd7);
      end
    end
    tick(1'b1, 1'b0, 8'h00);
    chk("f3_end_state", 64'(state_o), 64'(S_DONE));
    chk("f3_fd_early", 64'(frame_done), 64'd0);
    tick(1'b1, 1'b0, 8'h00);
    chk("f3_fd_pulse", 64'(frame_done), 64'd1);
    chk("f3_busy", 64'(busy), 64'd1);
    tick(1'b1, 1'b0, 8'h00);
    chk("f3_fd_once", 64'(frame_done), 64'd0);
    chk("f3_busy_held", 64'(busy), 64'd1);

    // Reset mid-capture after the high byte is latched
    tick(1'b0, 1'b0, 8'h00);
    chk("f4_state", 64'(state_o), 64'(S_CAPT));
    tick(1'b0, 1'b1, 8'hAA);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_state", 64'(state_o), 64'(S_IDLE));
    chk("mid_rst_addr", 64'(addr_in), 64'd0);
    chk("mid_rst_data", 64'(data_in), 64'd0);
    chk("mid_rst_regwrite", 64'(regwrite), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_fd", 64'(frame_done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick(1'b0, 1'b1, 8'hBB);
    chk("post_rst_nowr1", 64'(regwrite), 64'd0);
    tick(1'b0, 1'b1, 8'hCC);
    chk("post_rst_nowr2", 64'(regwrite), 64'd0);
    chk("post_rst_state", 64'(state_o), 64'(S_WAIT));

    // Arming mid-frame
    capture_en = 1'b0;
    tick(1'b0, 1'b1, 8'hDD);
    chk("disarm_wait_state", 64'(state_o), 64'(S_IDLE));
    chk("disarm_wait_busy", 64'(busy), 64'd0);
    capture_en = 1'b1;
    tick(1'b0, 1'b1, 8'h11);
    tick(1'b0, 1'b1, 8'h22);
    chk("midframe_nowr1", 64'(regwrite), 64'd0);
    tick(1'b0, 1'b1, 8'h33);
    tick(1'b0, 1'b1, 8'h44);
    chk("midframe_nowr2", 64'(regwrite), 64'd0);
    chk("midframe_state", 64'(state_o), 64'(S_WAIT));
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    chk("f5_state", 64'(state_o), 64'(S_CAPT));
    tick(1'b0, 1'b1, 8'h5A);
    tick(1'b0, 1'b1, 8'hA5);
    exp_wr(17'd0, 16'h5AA5);

    // Disarm during capture
    capture_en = 1'b0;
    tick(1'b0, 1'b1, 8'hC0);
    tick(1'b0, 1'b1, 8'hDE);
    chk("disarm_capt_state", 64'(state_o), 64'(S_CAPT));
    exp_wr(17'd1, 16'hC0DE);
    tick(1'b1, 1'b0, 8'h00);
    chk("f5_end_state", 64'(state_o), 64'(S_DONE));
    tick(1'b1, 1'b0, 8'h00);
    chk("f5_fd_pulse", 64'(frame_done), 64'd1);
    chk("f5_idle_state", 64'(state_o), 64'(S_IDLE));
    chk("f5_idle_busy", 64'(busy), 64'd0);
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'h12);
    tick(1'b0, 1'b1, 8'h34);
    chk("disarmed_nowr", 64'(regwrite), 64'd0);
    chk("disarmed_state", 64'(state_o), 64'(S_IDLE));
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);

    // Scoreboard: every observed write against the expected queue
    chk("sb_count", 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      chk("sb_write", 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
